serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor: it computes A+B or A−B on WIDTH-bit operands, one bit per clock, LSB first. A single instance of the existing `full_adder` cell does the arithmetic, with a registered carry between bits. Operands arrive over a ready/valid input handshake and the result leaves over a ready/valid output handshake. It is the area-minimal arithmetic block for datapaths where latency is cheap and gates are not.

---
 rtl/serial_addsub_pkg.sv | 14 +
 rtl/full_adder.sv | 15 +
 rtl/serial_addsub.sv | 110 +++++++++++
 tb/tb_serial_addsub.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial adder family.
//   ADDER_DEFAULT_WIDTH : default operand width used by adder variants
//   state_t             : controller state encoding (IDLE=0, RUN=1, DONE=2)
package serial_addsub_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full_adder, one result bit per clock,
// LSB first. Subtraction is done as A + ~B + 1 (inverted B, carry preset).
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, sub sampled on accept)
//   out_valid / out_ready: result handshake (sum, cout, ovf held in DONE)
//   sum                  : result modulo 2^WIDTH
//   cout                 : carry out of MSB (for subtract: 1 = no borrow)
//   ovf                  : signed overflow (carry into MSB ^ carry out of MSB)
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             step;
  logic             last;

  assign accept   = (state == ST_IDLE) && in_valid;
  assign step     = (state == ST_RUN);
  assign last     = step && (cnt == LAST_BIT);
  assign in_ready = (state == ST_IDLE);

  full_adder u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Control, carry, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Preset carry to 1 for subtract: completes the two's complement of B.
        carry <= sub;
        cnt   <= '0;
      end else if (step) begin
        carry <= fa_cout;
        cnt   <= cnt + 1'b1;
        sum   <= {fa_sum, sum[WIDTH-1:1]};
        if (last) begin
          // 'carry' still holds the carry into the MSB at this edge.
          ovf       <= carry ^ fa_cout;
          cout      <= fa_cout;
          out_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Operand shift registers: loaded on accept, fully consumed before reuse,
  // so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr <= a;
      b_sr <= b ^ {WIDTH{sub}};
    end else if (step) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic       clk;
  logic       rst_n;

  logic       in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  logic       in_valid4, in_ready4, sub4, out_valid4, out_ready4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  int checks;
  int errors;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    string      name;
  } vec_t;

  vec_t vecs[9];

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic op8(input vec_t v);
    int n;
    n = 0;
    while (!in_ready8 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({v.name, "_in_ready"}, int'(in_ready8), 1);
    a8 = v.a; b8 = v.b; sub8 = v.sub; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs after accept: they must be ignored.
    in_valid8 = 1'b0; a8 = ~v.a; b8 = 8'($urandom); sub8 = ~v.sub;
    n = 0;
    while (!out_valid8 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk({v.name, "_latency"}, n, 8);
    chk({v.name, "_sum"},  int'(sum8),  int'(v.sum));
    chk({v.name, "_cout"}, int'(cout8), int'(v.cout));
    chk({v.name, "_ovf"},  int'(ovf8),  int'(v.ovf));
    chk({v.name, "_ready_in_done"}, int'(in_ready8), 0);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk({v.name, "_valid_drop"}, int'(out_valid8), 0);
    chk({v.name, "_back_idle"},  int'(in_ready8), 1);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid8 = 0; a8 = 0; b8 = 0; sub8 = 0; out_ready8 = 0;
    in_valid4 = 0; a4 = 0; b4 = 0; sub4 = 0; out_ready4 = 0;

    vecs[0] = '{8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0, "add_3c_25"};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01"};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01"};
    vecs[3] = '{8'h50, 8'h70, 1'b1, 8'hE0, 1'b0, 1'b0, "sub_50_70"};
    vecs[4] = '{8'h25, 8'h25, 1'b1, 8'h00, 1'b1, 1'b0, "sub_25_25"};
    vecs[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, "sub_00_01"};
    vecs[6] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, "sub_7f_ff"};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, "add_a5_5a"};
    vecs[8] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01"};

    #12;
    chk("rst_in_ready",  int'(in_ready8),  1);
    chk("rst_out_valid", int'(out_valid8), 0);
    chk("rst_sum",       int'(sum8),       0);
    chk("rst_cout",      int'(cout8),      0);
    chk("rst_ovf",       int'(ovf8),       0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) op8(vecs[i]);

    // Backpressure: hold DONE with inputs toggling.
    a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_latency", n, 8);
    for (int k = 0; k < 5; k++) begin
      out_ready8 = 1'b0;
      in_valid8  = 1'(k % 2 == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_sum",       int'(sum8),       8'h80);
      chk("bp_cout",      int'(cout8),      0);
      chk("bp_ovf",       int'(ovf8),       1);
      chk("bp_in_ready",  int'(in_ready8),  0);
      chk("bp_out_valid", int'(out_valid8), 1);
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("bp_release_valid", int'(out_valid8), 0);
    chk("bp_release_ready", int'(in_ready8),  1);
    @(posedge clk); #1;
    chk("bp_no_queued_op", int'(in_ready8), 1);

    // Asynchronous reset after 3 RUN edges.
    a8 = 8'h55; b8 = 8'h0F; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  int'(in_ready8),  1);
    chk("mid_rst_out_valid", int'(out_valid8), 0);
    chk("mid_rst_sum",       int'(sum8),       0);
    chk("mid_rst_cout",      int'(cout8),      0);
    chk("mid_rst_ovf",       int'(ovf8),       0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", int'(in_ready8), 1);
    op8('{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "post_rst_add"});

    // WIDTH=4 exhaustive against an arithmetic reference model.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int s = 0; s < 2; s++) begin
          int sa, sb, r, es, ec, eo, lat;
          logic [3:0] hs;
          logic hc, ho;
          sa = (ai >= 8) ? ai - 16 : ai;
          sb = (bi >= 8) ? bi - 16 : bi;
          if (s == 1) begin
            es = (ai - bi) & 15; ec = (ai >= bi) ? 1 : 0; r = sa - sb;
          end else begin
            es = (ai + bi) & 15; ec = (ai + bi > 15) ? 1 : 0; r = sa + sb;
          end
          eo = (r > 7 || r < -8) ? 1 : 0;
          a4 = 4'(ai); b4 = 4'(bi); sub4 = 1'(s); in_valid4 = 1'b1;
          out_ready4 = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
          lat = 0;
          while (!out_valid4 && lat < 20) begin
            out_ready4 = 1'($urandom_range(0, 1));
            @(posedge clk); #1; lat++;
          end
          chk("w4_latency", lat, 4);
          chk("w4_sum",  int'(sum4),  es);
          chk("w4_cout", int'(cout4), ec);
          chk("w4_ovf",  int'(ovf4),  eo);
          hs = sum4; hc = cout4; ho = ovf4;
          n = 0;
          while (out_valid4 && n < 20) begin
            out_ready4 = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
            if (out_valid4) chk("w4_hold", int'({hs, hc, ho}), int'({sum4, cout4, ovf4}));
          end
          chk("w4_release", int'(out_valid4), 0);
          out_ready4 = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
